// File: rtl/move_list_pkg.sv
// Shared types and constants for the move-list controller.
package move_list_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST,
    ST_WAIT,
    ST_POP,
    ST_LATCH,
    ST_SCAN,
    ST_WCNT,
    ST_WTERM,
    ST_DONE
  } state_e;

  // Reg-0 bit positions
  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_DONE    = 1;
  localparam int unsigned CTRL_OVF     = 2;
  localparam int unsigned CTRL_TMO     = 3;
  localparam int unsigned CTRL_CNT_LSB = 16;
  localparam int unsigned CTRL_CNT_W   = 16;

  // Register map
  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_BOARD0 = 2;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned REG_AW     = 4;

  // Upper bounds accepted by the slot extractor
  localparam int unsigned SLOT_MAX_W = 64;
  localparam int unsigned WORD_MAX_W = 1024;

  // Returns slot idx of a packed FIFO word as {invalid, move}, zero-extended
  function automatic logic [SLOT_MAX_W-1:0] get_slot(input logic [WORD_MAX_W-1:0] word,
                                                     input int unsigned idx,
                                                     input int unsigned slot_w);
    logic [SLOT_MAX_W-1:0] mask;
    mask = (SLOT_MAX_W'(1) << slot_w) - SLOT_MAX_W'(1);
    return SLOT_MAX_W'(word >> (idx * slot_w)) & mask;
  endfunction

endpackage

// File: rtl/move_list_regs.sv
// 16-word register file with board-state export and latency-1 read mux.
module move_list_regs
  import move_list_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned BOARD_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_WIDTH-1:0]    addr_i,
  input  logic                     rd_i,
  input  logic                     wr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [DATA_WIDTH-1:0]    ram_q_i,
  input  logic                     done_i,
  input  logic                     ovf_i,
  input  logic                     tmo_i,
  input  logic [CTRL_CNT_W-1:0]    count_i,
  output logic                     start_o,
  output logic [32*BOARD_WORDS-1:0] bstate_o,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  if (REG_BOARD0 + BOARD_WORDS > NUM_REGS) begin : g_bad_board
    $error("BOARD_WORDS does not fit in the register file");
  end
  if (DATA_WIDTH < 32) begin : g_bad_dw
    $error("DATA_WIDTH must be at least 32");
  end

  logic                  is_reg_c;
  logic [REG_AW-1:0]     idx_c;
  logic                  start_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] ctrl_c;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  sel_ram_q;

  assign is_reg_c = addr_i < ADDR_WIDTH'(NUM_REGS);
  assign idx_c    = addr_i[REG_AW-1:0];
  assign start_o  = start_q;

  // Control word: only start is stored here, status bits come from the FSM
  always_comb begin
    ctrl_c                               = '0;
    ctrl_c[CTRL_START]                   = start_q;
    ctrl_c[CTRL_DONE]                    = done_i;
    ctrl_c[CTRL_OVF]                     = ovf_i;
    ctrl_c[CTRL_TMO]                     = tmo_i;
    ctrl_c[CTRL_CNT_LSB +: CTRL_CNT_W]   = count_i;
  end

  // Slave writes; a reg-0 write touches only the start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_i && is_reg_c) begin
      if (idx_c == REG_AW'(REG_CTRL)) start_q <= wdata_i[CTRL_START];
      else                            regs_q[idx_c] <= wdata_i;
    end
  end

  // Read capture; RAM data arrives one cycle later so only the select is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '0;
      sel_ram_q <= 1'b0;
    end else if (rd_i) begin
      sel_ram_q <= !is_reg_c;
      rd_q      <= (idx_c == REG_AW'(REG_CTRL)) ? ctrl_c : regs_q[idx_c];
    end
  end

  assign rdata_o = sel_ram_q ? ram_q_i : rd_q;

  for (genvar b = 0; b < BOARD_WORDS; b++) begin : g_bstate
    assign bstate_o[32*b +: 32] = regs_q[REG_BOARD0 + b][31:0];
  end

endmodule

// File: rtl/move_list_ctrl.sv
// Move-list controller: drains LMG FIFO words and compacts valid moves into RAM.
// Optional watchdog enabled by defining MOVE_LIST_CTRL_TIMEOUT_EN.
module move_list_ctrl
  import move_list_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned SLOTS       = 8,
  parameter int unsigned MOVE_W      = 18,
  parameter int unsigned BOARD_WORDS = 8,
  parameter int unsigned LIST_BASE   = 16,
  parameter int unsigned MAX_MOVES   = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         slave_address,
  input  logic                          slave_read,
  input  logic                          slave_write,
  input  logic [DATA_WIDTH-1:0]         slave_writedata,
  output logic [DATA_WIDTH-1:0]         slave_readdata,
  output logic [ADDR_WIDTH-1:0]         ram_wraddr,
  output logic [ADDR_WIDTH-1:0]         ram_rdaddr,
  output logic [DATA_WIDTH-1:0]         ram_wrdata,
  output logic                          ram_wren,
  input  logic [DATA_WIDTH-1:0]         ram_q,
  output logic                          lmg_reset,
  output logic [32*BOARD_WORDS-1:0]     lmg_bstate,
  input  logic                          lmg_done,
  output logic                          lmg_rden,
  input  logic [SLOTS*(MOVE_W+1)-1:0]   lmg_fifo_out,
  output logic                          irq
);

  localparam int unsigned SLOT_W = MOVE_W + 1;
  localparam int unsigned WORD_W = SLOTS * SLOT_W;
  localparam int unsigned CNT_W  = $clog2(MAX_MOVES + 1);
  localparam int unsigned IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR   = ADDR_WIDTH'(LIST_BASE);
  localparam logic [ADDR_WIDTH-1:0] LIST_ADDR0 = ADDR_WIDTH'(LIST_BASE + 1);

  if (LIST_BASE + MAX_MOVES + 1 >= 2**ADDR_WIDTH) begin : g_bad_list
    $error("move list does not fit in the RAM address space");
  end
  if (CNT_W > CTRL_CNT_W || SLOT_W > SLOT_MAX_W || WORD_W > WORD_MAX_W || MOVE_W > DATA_WIDTH) begin : g_bad_geom
    $error("unsupported slot/count geometry");
  end

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic                    any_q, any_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic                    tmo_q, tmo_d;
  logic                    start_prev_q;
  logic                    lmg_reset_q, lmg_reset_d;
  logic                    lmg_rden_q, lmg_rden_d;
  logic                    ram_wren_q, ram_wren_d;
  logic [ADDR_WIDTH-1:0]   ram_wraddr_q, ram_wraddr_d;
  logic [DATA_WIDTH-1:0]   ram_wrdata_q, ram_wrdata_d;

  logic                    start_c;
  logic                    host_ram_wr_c;
  logic                    tmo_hit_c;
  logic [SLOT_W-1:0]       slot_c;
  logic                    slot_inv_c;
  logic [MOVE_W-1:0]       slot_move_c;

  move_list_regs #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BOARD_WORDS(BOARD_WORDS)
  ) u_regs (
    .clk      (clk),
    .rst_n    (reset),
    .addr_i   (slave_address),
    .rd_i     (slave_read),
    .wr_i     (slave_write),
    .wdata_i  (slave_writedata),
    .ram_q_i  (ram_q),
    .done_i   (done_q),
    .ovf_i    (ovf_q),
    .tmo_i    (tmo_q),
    .count_i  (CTRL_CNT_W'(count_q)),
    .start_o  (start_c),
    .bstate_o (lmg_bstate),
    .rdata_o  (slave_readdata)
  );

  assign host_ram_wr_c = slave_write && (slave_address >= ADDR_WIDTH'(NUM_REGS));
  assign slot_c        = SLOT_W'(get_slot(WORD_MAX_W'(word_q), 32'(idx_q), SLOT_W));
  assign slot_inv_c    = slot_c[MOVE_W];
  assign slot_move_c   = slot_c[MOVE_W-1:0];

`ifdef MOVE_LIST_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = 20;
  logic [TMO_W-1:0] tmo_cnt_q;

  // Watchdog counts while the LMG is being waited on or drained
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                                                tmo_cnt_q <= '0;
    else if (state_q inside {ST_WAIT, ST_POP, ST_LATCH, ST_SCAN, ST_WCNT, ST_WTERM}) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    else                                                                       tmo_cnt_q <= '0;
  end

  assign tmo_hit_c = (tmo_cnt_q == '1) && (state_q inside {ST_WAIT, ST_POP, ST_LATCH, ST_SCAN});
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    any_d        = any_q;
    count_d      = count_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    tmo_d        = tmo_q;
    lmg_reset_d  = 1'b0;
    lmg_rden_d   = 1'b0;
    ram_wren_d   = 1'b0;
    ram_wraddr_d = ram_wraddr_q;
    ram_wrdata_d = ram_wrdata_q;

    if (!start_c && !(state_q inside {ST_IDLE, ST_DONE})) begin
      // Abort: reset the LMG and leave the list untouched
      lmg_reset_d = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (host_ram_wr_c) begin
            ram_wren_d   = 1'b1;
            ram_wraddr_d = slave_address;
            ram_wrdata_d = slave_writedata;
          end
          if (state_q == ST_DONE) begin
            if (!start_c) begin
              done_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else if (start_c && !start_prev_q) begin
            done_d      = 1'b0;
            ovf_d       = 1'b0;
            tmo_d       = 1'b0;
            count_d     = '0;
            lmg_reset_d = 1'b1;
            state_d     = ST_RST;
          end
        end
        ST_RST: state_d = ST_WAIT;
        ST_WAIT: begin
          if (tmo_hit_c) begin
            tmo_d   = 1'b1;
            state_d = ST_WCNT;
          end else if (lmg_done) begin
            lmg_rden_d = 1'b1;
            state_d    = ST_POP;
          end
        end
        ST_POP: begin
          if (tmo_hit_c) begin
            tmo_d   = 1'b1;
            state_d = ST_WCNT;
          end else begin
            state_d = ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (tmo_hit_c) begin
            tmo_d   = 1'b1;
            state_d = ST_WCNT;
          end else begin
            word_d  = lmg_fifo_out;
            idx_d   = '0;
            any_d   = 1'b0;
            state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (tmo_hit_c) begin
            tmo_d   = 1'b1;
            state_d = ST_WCNT;
          end else if (!slot_inv_c && count_q == CNT_W'(MAX_MOVES)) begin
            ovf_d   = 1'b1;
            state_d = ST_WCNT;
          end else begin
            if (!slot_inv_c) begin
              ram_wren_d   = 1'b1;
              ram_wraddr_d = LIST_ADDR0 + ADDR_WIDTH'(count_q);
              ram_wrdata_d = DATA_WIDTH'(slot_move_c);
              count_d      = count_q + CNT_W'(1);
              any_d        = 1'b1;
            end
            if (idx_q == IDX_W'(SLOTS - 1)) begin
              if (any_q || !slot_inv_c) begin
                lmg_rden_d = 1'b1;
                state_d    = ST_POP;
              end else begin
                state_d = ST_WCNT;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        ST_WCNT: begin
          ram_wren_d   = 1'b1;
          ram_wraddr_d = CNT_ADDR;
          ram_wrdata_d = DATA_WIDTH'(count_q);
          state_d      = ST_WTERM;
        end
        ST_WTERM: begin
          ram_wren_d   = 1'b1;
          ram_wraddr_d = LIST_ADDR0 + ADDR_WIDTH'(count_q);
          ram_wrdata_d = '0;
          done_d       = 1'b1;
          state_d      = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q        <= '0;
      word_q       <= '0;
      any_q        <= 1'b0;
      count_q      <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      start_prev_q <= 1'b0;
      lmg_reset_q  <= 1'b0;
      lmg_rden_q   <= 1'b0;
      ram_wren_q   <= 1'b0;
      ram_wraddr_q <= '0;
      ram_wrdata_q <= '0;
    end else begin
      idx_q        <= idx_d;
      word_q       <= word_d;
      any_q        <= any_d;
      count_q      <= count_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      start_prev_q <= start_c;
      lmg_reset_q  <= lmg_reset_d;
      lmg_rden_q   <= lmg_rden_d;
      ram_wren_q   <= ram_wren_d;
      ram_wraddr_q <= ram_wraddr_d;
      ram_wrdata_q <= ram_wrdata_d;
    end
  end

  assign ram_rdaddr = slave_address;
  assign ram_wraddr = ram_wraddr_q;
  assign ram_wrdata = ram_wrdata_q;
  assign ram_wren   = ram_wren_q;
  assign lmg_reset  = lmg_reset_q;
  assign lmg_rden   = lmg_rden_q;
  assign irq        = done_q;

endmodule

// File: tb/tb_move_list_ctrl.sv
// Bench for move_list_ctrl: bus register table plus list-building sequences.
module tb_move_list_ctrl;

  localparam int unsigned MAXM   = 4;
  localparam int unsigned WORD_W = 8 * 19;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [14:0]       slave_address;
  logic              slave_read, slave_write;
  logic [31:0]       slave_writedata, slave_readdata;
  logic [14:0]       ram_wraddr, ram_rdaddr;
  logic [31:0]       ram_wrdata, ram_q;
  logic              ram_wren;
  logic              lmg_reset, lmg_done, lmg_rden, irq;
  logic [255:0]      lmg_bstate;
  logic [WORD_W-1:0] lmg_fifo_out;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [14:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [14:0] addr; logic [31:0] wdata; logic [31:0] rexp; } reg_vec_t;

  wr_t               exp_q[$];
  logic [WORD_W-1:0] fifo_q[$];
  logic [31:0]       mem [128];
  wr_t               mon_e;

  always #5 clk = ~clk;

  move_list_ctrl #(.MAX_MOVES(MAXM)) dut (
    .clk(clk), .reset(rst_n),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
    .ram_wraddr(ram_wraddr), .ram_rdaddr(ram_rdaddr), .ram_wrdata(ram_wrdata),
    .ram_wren(ram_wren), .ram_q(ram_q),
    .lmg_reset(lmg_reset), .lmg_bstate(lmg_bstate), .lmg_done(lmg_done),
    .lmg_rden(lmg_rden), .lmg_fifo_out(lmg_fifo_out), .irq(irq)
  );

  function automatic logic [WORD_W-1:0] mk_word(input logic [7:0] vmask, input logic [143:0] moves);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < 8; i++) w[i*19 +: 19] = {~vmask[i], moves[i*18 +: 18]};
    return w;
  endfunction

  // RAM model, 1-cycle read latency
  always @(posedge clk) begin
    if (ram_wren && ram_wraddr < 15'd128) mem[ram_wraddr[6:0]] <= ram_wrdata;
    ram_q <= (ram_rdaddr < 15'd128) ? mem[ram_rdaddr[6:0]] : 32'h0;
  end

  // LMG FIFO model: data valid the cycle after the pop
  always @(posedge clk) begin
    if (lmg_rden) begin
      if (fifo_q.size() > 0) lmg_fifo_out <= fifo_q.pop_front();
      else                   lmg_fifo_out <= mk_word(8'h00, 144'h0);
    end
  end

  // Scoreboard on RAM writes
  always @(negedge clk) begin
    if (rst_n && ram_wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ram_wr: got unexpected write addr=%0h data=%0h, required none", ram_wraddr, ram_wrdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (ram_wraddr !== mon_e.addr || ram_wrdata !== mon_e.data) begin
          errors++;
          $display("FAIL ram_wr: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   ram_wraddr, ram_wrdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic push_wr(input logic [14:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic bus_write(input logic [14:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic bus_read(input logic [14:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    @(negedge clk);
    slave_read = 1'b0;
    d = slave_readdata;
  endtask

  task automatic wait_irq(input string nm);
    int n = 0;
    while (irq !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk(nm, 64'(irq), 64'd1);
  endtask

  task automatic wait_rden(input string nm);
    int n = 0;
    while (lmg_rden !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk(nm, 64'(lmg_rden), 64'd1);
  endtask

  task automatic stop_run(input string nm);
    bus_write(15'd0, 32'd0);
    @(negedge clk);
    chk(nm, 64'(irq), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reg_vec_t    vecs[6];
    logic [31:0] d;
    int          pulses;

    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    ram_q = 32'h0; lmg_fifo_out = '0; lmg_done = 1'b0;
    slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_readdata", 64'(slave_readdata), 64'd0);
    chk("rst_outs", 64'({ram_wren, lmg_reset, lmg_rden, irq}), 64'd0);
    chk("rst_ramaddr", 64'({ram_wraddr, ram_wrdata}), 64'd0);
    chk("rst_bstate", 64'(lmg_bstate[63:0]), 64'd0);
    rst_n = 1'b1;
    bus_read(15'd0, d);
    chk("rst_reg0", 64'(d), 64'd0);

    // Register/RAM access table
    vecs[0] = '{15'd1,    32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{15'd2,    32'h11111111, 32'h11111111};
    vecs[2] = '{15'd9,    32'h99999999, 32'h99999999};
    vecs[3] = '{15'd15,   32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[4] = '{15'd0,    32'hFFFFFFFE, 32'h00000000};
    vecs[5] = '{15'h40,   32'h0000CAFE, 32'h0000CAFE};
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].addr >= 15'd16) push_wr(vecs[i].addr, vecs[i].wdata);
      bus_write(vecs[i].addr, vecs[i].wdata);
    end
    for (int i = 0; i < 6; i++) begin
      bus_read(vecs[i].addr, d);
      chk($sformatf("reg_tbl[%0d]", i), 64'(d), 64'(vecs[i].rexp));
    end
    chk("bstate_w0", 64'(lmg_bstate[31:0]), 64'h11111111);
    chk("bstate_w7", 64'(lmg_bstate[7*32 +: 32]), 64'h99999999);

    // Basic list: slots 0,2,5 valid then an empty word
    fifo_q.push_back(mk_word(8'b0010_0101, {18'h0, 18'h0, 18'h303, 18'h0, 18'h0, 18'h202, 18'h0, 18'h101}));
    fifo_q.push_back(mk_word(8'h00, 144'h0));
    push_wr(15'd17, 32'h101); push_wr(15'd18, 32'h202); push_wr(15'd19, 32'h303);
    push_wr(15'd16, 32'd3);   push_wr(15'd20, 32'd0);
    bus_write(15'd0, 32'd1);
    chk("lmg_reset_c1", 64'(lmg_reset), 64'd0);
    @(negedge clk);
    chk("lmg_reset_c2", 64'(lmg_reset), 64'd1);
    @(negedge clk);
    chk("lmg_reset_c3", 64'(lmg_reset), 64'd0);
    lmg_done = 1'b1;
    wait_irq("basic_done");
    bus_read(15'd0, d);
    chk("basic_reg0", 64'(d), 64'h0003_0003);
    bus_read(15'd16, d); chk("basic_ram16", 64'(d), 64'd3);
    bus_read(15'd17, d); chk("basic_ram17", 64'(d), 64'h101);
    bus_read(15'd19, d); chk("basic_ram19", 64'(d), 64'h303);
    bus_read(15'd20, d); chk("basic_ram20", 64'(d), 64'd0);
    chk("basic_sb_empty", 64'(exp_q.size()), 64'd0);
    stop_run("basic_irq_clear");

    // Empty position and finish latency
    fifo_q.push_back(mk_word(8'h00, 144'h0));
    push_wr(15'd16, 32'd0); push_wr(15'd17, 32'd0);
    bus_write(15'd0, 32'd1);
    wait_rden("empty_pop");
    repeat (11) @(negedge clk);
    chk("empty_done_early", 64'(irq), 64'd0);
    @(negedge clk);
    chk("empty_done_on_time", 64'(irq), 64'd1);
    bus_read(15'd0, d);
    chk("empty_reg0", 64'(d), 64'h0000_0003);
    chk("empty_sb_empty", 64'(exp_q.size()), 64'd0);
    stop_run("empty_irq_clear");

    // Overflow: six valid moves into a four-entry list
    fifo_q.push_back(mk_word(8'b0011_1111, {18'h0, 18'h0, 18'h16, 18'h15, 18'h14, 18'h13, 18'h12, 18'h11}));
    push_wr(15'd17, 32'h11); push_wr(15'd18, 32'h12); push_wr(15'd19, 32'h13); push_wr(15'd20, 32'h14);
    push_wr(15'd16, 32'd4);  push_wr(15'd21, 32'd0);
    bus_write(15'd0, 32'd1);
    wait_irq("ovf_done");
    bus_read(15'd0, d);
    chk("ovf_reg0", 64'(d), 64'h0004_0007);
    bus_read(15'd16, d); chk("ovf_ram16", 64'(d), 64'd4);
    bus_read(15'd21, d); chk("ovf_ram21", 64'(d), 64'd0);
    chk("ovf_sb_empty", 64'(exp_q.size()), 64'd0);
    stop_run("ovf_irq_clear");

    // Abort mid-SCAN
    fifo_q.push_back(mk_word(8'b1000_0001, {18'h38, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h31}));
    push_wr(15'd17, 32'h31);
    bus_write(15'd0, 32'd1);
    wait_rden("abort_pop");
    @(negedge clk);
    @(negedge clk);
    slave_address = 15'd0; slave_writedata = 32'd0; slave_write = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      slave_write = 1'b0;
      if (lmg_reset === 1'b1) pulses++;
    end
    chk("abort_reset_pulses", 64'(pulses), 64'd1);
    chk("abort_irq", 64'(irq), 64'd0);
    bus_read(15'd0, d);
    chk("abort_reg0_bits", 64'(d[3:0]), 64'd0);
    chk("abort_sb_empty", 64'(exp_q.size()), 64'd0);

    // Clean restart after abort
    fifo_q.push_back(mk_word(8'b0000_0010, {18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h41, 18'h0}));
    fifo_q.push_back(mk_word(8'h00, 144'h0));
    push_wr(15'd17, 32'h41); push_wr(15'd16, 32'd1); push_wr(15'd18, 32'd0);
    bus_write(15'd0, 32'd1);
    wait_irq("restart_done");
    bus_read(15'd0, d);
    chk("restart_reg0", 64'(d), 64'h0001_0003);
    chk("restart_sb_empty", 64'(exp_q.size()), 64'd0);
    stop_run("restart_irq_clear");

    // Bus conflict during SCAN
    fifo_q.push_back(mk_word(8'b0000_0001, {18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h77}));
    fifo_q.push_back(mk_word(8'h00, 144'h0));
    push_wr(15'd17, 32'h77); push_wr(15'd16, 32'd1); push_wr(15'd18, 32'd0);
    bus_write(15'd0, 32'd1);
    wait_rden("conflict_pop");
    @(negedge clk);
    @(negedge clk);
    slave_address = 15'h40; slave_writedata = 32'h0BAD; slave_write = 1'b1;
    @(negedge clk);
    slave_address = 15'd5; slave_writedata = 32'h55AA;
    @(negedge clk);
    slave_write = 1'b0;
    chk("conflict_bstate_reg5", 64'(lmg_bstate[3*32 +: 32]), 64'h55AA);
    wait_irq("conflict_done");
    bus_read(15'h40, d);
    chk("conflict_ram40_kept", 64'(d), 64'h0000CAFE);
    chk("conflict_sb_empty", 64'(exp_q.size()), 64'd0);
    stop_run("conflict_irq_clear");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_list_ctrl.md
# move_list_ctrl

Parametrised Avalon-MM control block between the HPS bus and the legal-move generator (LMG). Software writes a board state and a start bit. The block resets the LMG and drains its FIFO one packed word at a time. It compacts the valid move slots into an external block RAM, then writes a move count and a zero terminator and raises done. It generalises the move-list controller to any slot count and move width, and adds overflow, abort and optional watchdog handling.

## Interface
- DATA_WIDTH, 32: Avalon data width; all register and RAM words.
- ADDR_WIDTH, 15: slave and RAM word-address width.
- SLOTS, 8: move slots per LMG FIFO word.
- MOVE_W, 18: move payload bits per slot; the slot is MOVE_W+1 bits, bit MOVE_W = invalid flag (1 = invalid).
- BOARD_WORDS, 8: board-state words at regs 2..2+BOARD_WORDS-1; reg 2 maps to LSBs.
- LIST_BASE, 16: RAM address of the count word; moves start at LIST_BASE+1.
- MAX_MOVES, 255: list capacity.
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- slave_address  in  ADDR_WIDTH  word address.
- slave_read / slave_write  in  1  Avalon strobes; no waitrequest.
- slave_writedata  in  DATA_WIDTH  write data.
- slave_readdata  out  DATA_WIDTH  read data, fixed read latency 1.
- ram_wraddr / ram_rdaddr  out  ADDR_WIDTH  RAM ports.
- ram_wrdata  out  DATA_WIDTH  RAM write data; moves are zero-extended.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DATA_WIDTH  RAM read data, 1-cycle latency.
- lmg_reset  out  1  one-cycle LMG reset pulse.
- lmg_bstate  out  32*BOARD_WORDS  board state from the register file.
- lmg_done  in  1  LMG has results in its FIFO.
- lmg_rden  out  1  FIFO pop; lmg_fifo_out is valid the cycle after.
- lmg_fifo_out  in  SLOTS*(MOVE_W+1)  packed slots, slot 0 in LSBs.
- irq  out  1  level; equals done.

## Operation
- Register file: 16 words at addresses 0..15. Reg 0 layout:
  - bit0 start (RW).
  - bit1 done (RO).
  - bit2 overflow (RO).
  - bit3 timeout (RO).
  - [31:16] move count (RO).
- Reg 1 is scratch. Regs 2..15 are RW; board words sit inside this range.
- A slave write to address ≥16 writes the RAM only in IDLE or DONE. Such writes in other states are dropped.
- Reads: addresses <16 return the register; all others return ram_q.
- FSM states:
  - IDLE: a rising edge on start → RST; clears done, overflow, timeout and count.
  - RST: assert lmg_reset for 1 cycle → WAIT.
  - WAIT: lmg_done=1 → POP.
  - POP: assert lmg_rden → LATCH.
  - LATCH: capture lmg_fifo_out into a word register; slot index i=0 → SCAN.
  - SCAN: one slot per cycle. For a valid slot, write the move to LIST_BASE+1+count and increment count. At i=SLOTS-1: if the word had zero valid slots → WCNT, else → POP.
  - WCNT: write count to LIST_BASE → WTERM.
  - WTERM: write 0 to LIST_BASE+1+count → DONE.
  - DONE: set done; start=0 → IDLE and clear done.
- Overflow: a valid slot seen with count==MAX_MOVES sets overflow, skips the write and goes → WCNT.
- Abort: start cleared in any state other than IDLE or DONE → one lmg_reset pulse → IDLE. The list is left unwritten and done stays 0.
- Same cycle as an FSM update: a slave write to reg 0 updates only bit0. The FSM-owned bits are never slave-writable.

## Timing
- Reset values:
  - slave_readdata, ram_*, lmg_reset, lmg_rden, irq = 0.
  - Register file all 0; FSM in IDLE.
- Start edge detection: compare bit0 against its registered copy.
- Start write → lmg_reset pulse: 2 cycles.
- Per FIFO word: 2+SLOTS cycles (POP, LATCH, SCAN).
- List-finish latency: after the all-invalid word's SCAN, 2 cycles to done.
- Count arithmetic: width ⌈log2(MAX_MOVES+1)⌉. Address arithmetic in ADDR_WIDTH, no wrap. Elaboration error if LIST_BASE+MAX_MOVES+1 ≥ 2^ADDR_WIDTH.
- slave_readdata is registered: valid the cycle after slave_read.

## Configuration
- MOVE_LIST_CTRL_TIMEOUT_EN, defined:
  - A 20-bit counter runs in WAIT and in POP-to-final-WTERM.
  - At 2^20-1 cycles it sets timeout and done and writes count, then → DONE through WCNT/WTERM.
- Undefined: no counter; WAIT blocks indefinitely; timeout bit reads 0.

## Structure
- Package move_list_pkg holds:
  - FSM state enum.
  - Reg-0 bit index constants.
  - Register-map constants (REG_CTRL=0, REG_BOARD0=2).
  - Slot-extraction function (slot i → {invalid, move}).
- One sub-module, move_list_regs: 16-word register file plus the readdata mux with latency 1.

## Test plan
- Basic list:
  - Board written, start=1; LMG gives one word with slots 0,2,5 valid (moves 0x101, 0x202, 0x303), then an all-invalid word.
  - Required: RAM[16]=3, RAM[17..19]=0x101/0x202/0x303, RAM[20]=0, done=1, reg0[31:16]=3.
- Empty position: first word all-invalid → RAM[16]=0, RAM[17]=0, done 2 cycles after that word's SCAN.
- Overflow:
  - MAX_MOVES=4; 6 valid moves supplied.
  - Required: RAM[16]=4, RAM[21]=0, overflow=1, done=1; the fifth move is never written.
- Abort: start cleared mid-SCAN → lmg_reset pulses once, FSM IDLE, done=0. A subsequent start runs cleanly with count from 0.
- Bus conflict: a slave write to 0x40 during SCAN is dropped; a slave write to reg 5 in the same cycle is visible on lmg_bstate the next cycle.
- Timeout (macro on): lmg_done held 0 → timeout=1, done=1, RAM[16]=0 after 2^20 cycles.
